osc_phase_accum: RTL and testbench
==================================

// Module: osc_phase_accum
// PURPOSE
// Time-multiplexed phase accumulator directly downstream of the pitch stage. Each valid
// slot adds osc_pitch_val to a stored per-(voice,osc) phase word and emits the updated
// phase to the wavetable/sine lookup. Also handles note-on phase restart and per-oscillator
// hard sync to oscillator 0 of the same voice.
// PARAMETERS
// VOICES    8   number of voices
// V_OSC     4   oscillators per voice
// V_WIDTH   3   log2(VOICES)
// O_WIDTH   2   log2(V_OSC)
// OE_WIDTH  1   sub-slot bits in xxxx (ignored for addressing)
// E_WIDTH   O_WIDTH+OE_WIDTH
// ACC_W     32  phase accumulator width; osc_pitch_val zero-extended to ACC_W
// OUT_W     16  phase_out width = acc[ACC_W-1 -: OUT_W]
// PORTS
// const_clk     in   1                   engine clock; all logic on posedge
// reset_reg_N   in   1                   synchronous reset, active low
// xxxx          in   V_WIDTH+E_WIDTH     slot index: vx=[V_WIDTH+E_WIDTH-1:E_WIDTH], ox=[E_WIDTH-1:OE_WIDTH]
// osc_pitch_val in   24                  phase increment for slot xxxx
// pitch_valid   in   1                   xxxx/osc_pitch_val valid this cycle
// note_on       in   1                   one-cycle pulse: restart all oscs of voice key_adr
// key_adr       in   V_WIDTH             voice restarted by note_on
// sync_mask     in   V_OSC               bit o=1: osc o (o>0) hard-synced to osc 0; bit 0 ignored
// phase_out     out  OUT_W               updated phase, top bits
// phase_vx      out  V_WIDTH             voice of phase_out
// phase_ox      out  O_WIDTH             osc of phase_out
// phase_wrap    out  1                   carry-out of this update (phase wrapped)
// phase_valid   out  1                   outputs valid this cycle
// BEHAVIOUR
// - Storage: phase RAM VOICES*V_OSC x ACC_W, address {vx,ox}, registered read; clr bitmap and
//   sync_pend[VOICES] in flops.
// - Pipeline, latency 2: S1 (cycle of pitch_valid) registers vx, ox, increment and issues the
//   RAM read. S2 forms base, computes {carry,sum}=base+inc (ACC_W+1 bits), writes sum back,
//   drives outputs. phase_valid is high exactly 2 cycles after each pitch_valid.
// - base select in S2, priority order: clr[vx,ox]=1 -> 0; sync applies -> 0; S2 address equals
//   previous S2 write address that cycle-1 -> forwarded sum; else RAM data.
//   Back-to-back same slot is therefore exact.
// - clr: set for all V_OSC bits of key_adr on note_on; bit cleared when its slot reaches S2.
//   Same-cycle set and clear of the same bit: set wins.
// - Sync: in S2 with ox=0, sync_pend[vx] <= carry (set or cleared each visit).
//   For ox>0 with sync_mask[ox]=1 and sync_pend[vx]=1, base=0 and phase_wrap=0.
//   Slots are visited ox ascending within a voice, so sync acts in the same frame.
// - Wrap: modulo 2^ACC_W; phase_wrap = carry (0 if base forced by sync).
//   clr restart still reports carry (always 0 since inc<2^24).
// - Reset (reset_reg_N=0 at posedge): all clr bits=1 (RAM not cleared, first visit restarts
//   from 0), sync_pend=0, pipeline valids=0, phase_out=0, phase_vx=0, phase_ox=0,
//   phase_wrap=0, phase_valid=0.
//   Reset mid-operation drops in-flight S1/S2 without writing RAM.
// - pitch_valid low: no RAM write, phase_valid=0 two cycles later, other outputs hold.
// - Throughput: one slot per cycle, no stalls; no backpressure input.
// TESTING
// 1 reset, slot v0/o0 inc=0x800000 x3 -> phase_out 0x0080,0x0100,0x0180; valid 2 cycles after
//   each strobe.
// 2 inc=0x800000 on v1/o0 x512 -> 512th update phase_out=0x0000, phase_wrap=1; all others 0.
// 3 v2/o0 advanced to 0x0300, note_on key_adr=2 -> next v2/o0 update phase_out=0x0080;
//   v3 unaffected.
// 4 note_on key_adr=4 in same cycle v4/o1 is in S2 -> that output uses old phase;
//   next v4/o1 update restarts from 0.
// 5 sync_mask=4'b0010, v5/o0 wraps -> v5/o1 same frame phase_out=inc>>16, v5/o2 continues
//   normally.
// 6 same slot v6/o3 inc=0x10000 strobed 4 consecutive cycles -> 0x0001,0x0002,0x0003,0x0004
//   (forwarding).

Source files
------------

// File: rtl/osc_phase_accum.sv
// Time-multiplexed per-(voice,osc) phase accumulator with note-on restart
// and per-voice hard sync to oscillator 0.
module osc_phase_accum #(
    parameter int VOICES   = 8,
    parameter int V_OSC    = 4,
    parameter int V_WIDTH  = 3,
    parameter int O_WIDTH  = 2,
    parameter int OE_WIDTH = 1,
    parameter int E_WIDTH  = O_WIDTH + OE_WIDTH,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 16
) (
    input  logic                       const_clk,
    input  logic                       reset_reg_N,
    input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    input  logic [23:0]                osc_pitch_val,
    input  logic                       pitch_valid,
    input  logic                       note_on,
    input  logic [V_WIDTH-1:0]         key_adr,
    input  logic [V_OSC-1:0]           sync_mask,
    output logic [OUT_W-1:0]           phase_out,
    output logic [V_WIDTH-1:0]         phase_vx,
    output logic [O_WIDTH-1:0]         phase_ox,
    output logic                       phase_wrap,
    output logic                       phase_valid
);

    localparam int SLOTS = VOICES * V_OSC;
    localparam int A_W   = V_WIDTH + O_WIDTH;

    logic [V_WIDTH-1:0] in_vx;
    logic [O_WIDTH-1:0] in_ox;
    logic [A_W-1:0]     in_addr;

    logic               s1_valid;
    logic [V_WIDTH-1:0] s1_vx;
    logic [O_WIDTH-1:0] s1_ox;
    logic [ACC_W-1:0]   s1_inc;
    logic [A_W-1:0]     s1_addr;

    logic [ACC_W-1:0]   ram [SLOTS];
    logic [ACC_W-1:0]   ram_q;

    logic               w_valid;
    logic [A_W-1:0]     w_addr;
    logic [ACC_W-1:0]   w_data;

    logic [SLOTS-1:0]   clr;
    logic [SLOTS-1:0]   clr_nxt;
    logic [VOICES-1:0]  sync_pend;

    logic               clr_hit;
    logic               sync_hit;
    logic               fwd_hit;
    logic               wr_en;
    logic [ACC_W-1:0]   base;
    logic [ACC_W-1:0]   sum;
    logic               carry;
    logic               unused_bits;

    assign in_vx   = xxxx[V_WIDTH+E_WIDTH-1:E_WIDTH];
    assign in_ox   = xxxx[E_WIDTH-1:OE_WIDTH];
    assign in_addr = {in_vx, in_ox};
    assign s1_addr = {s1_vx, s1_ox};
    assign unused_bits = ^{xxxx[OE_WIDTH-1:0], sync_mask[0]};

    always_ff @(posedge const_clk) begin
        if (!reset_reg_N) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= pitch_valid;
        end
        if (pitch_valid) begin
            s1_vx  <= in_vx;
            s1_ox  <= in_ox;
            s1_inc <= ACC_W'(osc_pitch_val);
        end
    end

    // Read-before-write RAM; the forward path covers the one-cycle hazard.
    always_ff @(posedge const_clk) begin
        if (pitch_valid) begin
            ram_q <= ram[in_addr];
        end
        if (wr_en) begin
            ram[s1_addr] <= sum;
        end
    end

    assign wr_en    = s1_valid & reset_reg_N;
    assign clr_hit  = clr[s1_addr];
    assign sync_hit = (s1_ox != '0) && sync_mask[s1_ox]
                      && sync_pend[s1_vx];
    assign fwd_hit  = w_valid && (w_addr == s1_addr);

    always_comb begin
        base = ram_q;
        if (clr_hit) begin
            base = '0;
        end else if (sync_hit) begin
            base = '0;
        end else if (fwd_hit) begin
            base = w_data;
        end
    end

    assign {carry, sum} = {1'b0, base} + {1'b0, s1_inc};

    // A restart request arriving with the clear of the same bit wins.
    always_comb begin
        clr_nxt = clr;
        if (s1_valid) begin
            clr_nxt[s1_addr] = 1'b0;
        end
        if (note_on) begin
            for (int i = 0; i < V_OSC; i++) begin
                clr_nxt[{key_adr, O_WIDTH'(i)}] = 1'b1;
            end
        end
    end

    always_ff @(posedge const_clk) begin
        if (!reset_reg_N) begin
            clr       <= '1;
            sync_pend <= '0;
            w_valid   <= 1'b0;
        end else begin
            clr     <= clr_nxt;
            w_valid <= s1_valid;
            if (s1_valid && s1_ox == '0) begin
                sync_pend[s1_vx] <= carry;
            end
        end
        w_addr <= s1_addr;
        w_data <= sum;
    end

    always_ff @(posedge const_clk) begin
        if (!reset_reg_N) begin
            phase_out   <= '0;
            phase_vx    <= '0;
            phase_ox    <= '0;
            phase_wrap  <= 1'b0;
            phase_valid <= 1'b0;
        end else begin
            phase_valid <= s1_valid;
            if (s1_valid) begin
                phase_out  <= sum[ACC_W-1 -: OUT_W];
                phase_vx   <= s1_vx;
                phase_ox   <= s1_ox;
                phase_wrap <= carry;
            end
        end
    end

endmodule

// File: tb/tb_osc_phase_accum.sv
// Directed bench for osc_phase_accum: vector table plus hand sequences
// for wrap, note-on restart, hard sync and back-to-back forwarding.
module tb_osc_phase_accum;

    logic        const_clk;
    logic        reset_reg_N;
    logic [5:0]  xxxx;
    logic [23:0] osc_pitch_val;
    logic        pitch_valid;
    logic        note_on;
    logic [2:0]  key_adr;
    logic [3:0]  sync_mask;
    logic [15:0] phase_out;
    logic [2:0]  phase_vx;
    logic [1:0]  phase_ox;
    logic        phase_wrap;
    logic        phase_valid;

    int checks = 0;
    int errors = 0;

    osc_phase_accum dut (
        .const_clk    (const_clk),
        .reset_reg_N  (reset_reg_N),
        .xxxx         (xxxx),
        .osc_pitch_val(osc_pitch_val),
        .pitch_valid  (pitch_valid),
        .note_on      (note_on),
        .key_adr      (key_adr),
        .sync_mask    (sync_mask),
        .phase_out    (phase_out),
        .phase_vx     (phase_vx),
        .phase_ox     (phase_ox),
        .phase_wrap   (phase_wrap),
        .phase_valid  (phase_valid)
    );

    initial const_clk = 1'b0;
    always #5 const_clk = ~const_clk;

    typedef struct {
        logic        pv;
        logic [2:0]  vx;
        logic [1:0]  ox;
        logic [23:0] inc;
        logic        note;
        logic [2:0]  key;
        logic [15:0] exp_out;
        logic        exp_wrap;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic pv, input logic [2:0] vx,
                       input logic [1:0] ox, input logic [23:0] inc,
                       input logic note, input logic [2:0] key,
                       input logic [15:0] eo, input logic ew);
        vec_t r;
        r = '{pv, vx, ox, inc, note, key, eo, ew};
        tbl.push_back(r);
    endtask

    task automatic tick();
        @(posedge const_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One isolated slot: strobe, then outputs appear after the second edge.
    task automatic run(input logic [2:0] v, input logic [1:0] o,
                       input logic [23:0] inc, input logic chk_en,
                       input logic [15:0] eo, input logic ew,
                       input string name);
        xxxx          = {v, o, 1'b0};
        osc_pitch_val = inc;
        pitch_valid   = 1'b1;
        tick();
        pitch_valid = 1'b0;
        if (chk_en) chk({name, "_valid_early"}, 32'(phase_valid), 32'd0);
        tick();
        if (chk_en) begin
            chk({name, "_valid"}, 32'(phase_valid), 32'd1);
            chk({name, "_vx"}, 32'(phase_vx), 32'(v));
            chk({name, "_ox"}, 32'(phase_ox), 32'(o));
            chk({name, "_out"}, 32'(phase_out), 32'(eo));
            chk({name, "_wrap"}, 32'(phase_wrap), 32'(ew));
        end
    endtask

    initial begin
        reset_reg_N   = 1'b0;
        xxxx          = '0;
        osc_pitch_val = '0;
        pitch_valid   = 1'b0;
        note_on       = 1'b0;
        key_adr       = '0;
        sync_mask     = '0;

        add(1, 0, 0, 24'h800000, 0, 0, 16'h0080, 0);
        add(1, 0, 0, 24'h800000, 0, 0, 16'h0100, 0);
        add(1, 0, 0, 24'h800000, 0, 0, 16'h0180, 0);
        for (int i = 1; i <= 6; i++)
            add(1, 2, 0, 24'h800000, 0, 0, 16'(i * 16'h80), 0);
        add(1, 3, 0, 24'h800000, 0, 0, 16'h0080, 0);
        add(1, 3, 0, 24'h800000, 0, 0, 16'h0100, 0);
        add(0, 0, 0, 24'h0, 1, 2, 16'h0, 0);
        add(1, 2, 0, 24'h800000, 0, 0, 16'h0080, 0);
        add(1, 3, 0, 24'h800000, 0, 0, 16'h0180, 0);

        tick();
        tick();
        chk("rst_out", 32'(phase_out), 32'd0);
        chk("rst_vx", 32'(phase_vx), 32'd0);
        chk("rst_ox", 32'(phase_ox), 32'd0);
        chk("rst_wrap", 32'(phase_wrap), 32'd0);
        chk("rst_valid", 32'(phase_valid), 32'd0);
        reset_reg_N = 1'b1;
        tick();

        foreach (tbl[i]) begin
            if (tbl[i].pv) begin
                run(tbl[i].vx, tbl[i].ox, tbl[i].inc, 1'b1,
                    tbl[i].exp_out, tbl[i].exp_wrap,
                    $sformatf("vec%0d", i));
            end else if (tbl[i].note) begin
                note_on = 1'b1;
                key_adr = tbl[i].key;
                tick();
                note_on = 1'b0;
            end
        end

        // 512 increments of 1/512 turn wrap exactly once, on the last.
        for (int i = 0; i < 512; i++) begin
            run(3'd1, 2'd0, 24'h800000, 1'b0, 16'h0, 1'b0, "w");
            chk($sformatf("wrap_out%0d", i), 32'(phase_out),
                32'(((i + 1) * 32'h80) & 32'hFFFF));
            chk($sformatf("wrap_c%0d", i), 32'(phase_wrap),
                32'(i == 511));
        end

        run(3'd4, 2'd1, 24'h010000, 1'b1, 16'h0001, 1'b0, "t4a");
        run(3'd4, 2'd1, 24'h010000, 1'b1, 16'h0002, 1'b0, "t4b");
        xxxx          = {3'd4, 2'd1, 1'b0};
        osc_pitch_val = 24'h010000;
        pitch_valid   = 1'b1;
        tick();
        pitch_valid = 1'b0;
        note_on     = 1'b1;
        key_adr     = 3'd4;
        tick();
        note_on = 1'b0;
        chk("t4_inflight", 32'(phase_out), 32'h0003);
        run(3'd4, 2'd1, 24'h010000, 1'b1, 16'h0001, 1'b0, "t4_restart");

        sync_mask = 4'b0010;
        run(3'd5, 2'd1, 24'h010000, 1'b1, 16'h0001, 1'b0, "t5a");
        run(3'd5, 2'd1, 24'h010000, 1'b1, 16'h0002, 1'b0, "t5b");
        run(3'd5, 2'd2, 24'h010000, 1'b1, 16'h0001, 1'b0, "t5c");
        for (int i = 0; i < 511; i++)
            run(3'd5, 2'd0, 24'h800000, 1'b0, 16'h0, 1'b0, "t5w");
        chk("t5_pre", 32'(phase_out), 32'hFF80);
        run(3'd5, 2'd0, 24'h800000, 1'b1, 16'h0000, 1'b1, "t5_o0wrap");
        run(3'd5, 2'd1, 24'h010000, 1'b1, 16'h0001, 1'b0, "t5_o1sync");
        run(3'd5, 2'd2, 24'h010000, 1'b1, 16'h0002, 1'b0, "t5_o2free");
        run(3'd5, 2'd0, 24'h800000, 1'b1, 16'h0080, 1'b0, "t5_o0next");
        run(3'd5, 2'd1, 24'h010000, 1'b1, 16'h0002, 1'b0, "t5_o1free");
        sync_mask = 4'b0000;

        xxxx          = {3'd6, 2'd3, 1'b0};
        osc_pitch_val = 24'h010000;
        pitch_valid   = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            tick();
            if (i == 3) pitch_valid = 1'b0;
            if (i >= 1) begin
                chk($sformatf("b2b_out%0d", i), 32'(phase_out), 32'(i));
                chk($sformatf("b2b_vld%0d", i), 32'(phase_valid), 32'd1);
            end
        end
        tick();
        chk("b2b_idle", 32'(phase_valid), 32'd0);
        chk("b2b_hold", 32'(phase_out), 32'h0004);

        reset_reg_N = 1'b0;
        tick();
        chk("rst2_out", 32'(phase_out), 32'd0);
        reset_reg_N = 1'b1;
        run(3'd6, 2'd3, 24'h010000, 1'b1, 16'h0001, 1'b0, "rst2_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
